// File: rtl/apb_fsm_controller.sv
// APB master-side sequencer of the AHB2APB bridge. It turns the slave interface's
// decoded transfer into APB setup/enable phases and stalls AHB through Hreadyout.
module apb_fsm_controller #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int NSEL   = 3
) (
   input  logic              Hclk,
   input  logic              Hresetn,
   input  logic              valid,
   input  logic              Hwritereg,
   input  logic [ADDR_W-1:0] Haddr1,
   input  logic [DATA_W-1:0] Hwdata1,
   input  logic [NSEL-1:0]   tempselx,
   output logic [NSEL-1:0]   Pselx,
   output logic              Penable,
   output logic              Pwrite,
   output logic [ADDR_W-1:0] Paddr,
   output logic [DATA_W-1:0] Pwdata,
   output logic              Hreadyout
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WWAIT   = 3'd1,
      READ    = 3'd2,
      RENABLE = 3'd3,
      WRITE   = 3'd4,
      WENABLE = 3'd5
   } state_t;

   state_t            state, state_n;
   logic [NSEL-1:0]   psel_n, wr_sel, wr_sel_n;
   logic              penable_n, pwrite_n, hready_n;
   logic [ADDR_W-1:0] paddr_n, wr_addr, wr_addr_n;
   logic [DATA_W-1:0] pwdata_n;

   always_comb begin
      // NOTE: every output gets a default before the case so no path infers a latch.
      state_n   = IDLE;
      psel_n    = Pselx;
      penable_n = 1'b0;
      pwrite_n  = Pwrite;
      paddr_n   = Paddr;
      pwdata_n  = Pwdata;
      hready_n  = 1'b1;
      wr_addr_n = wr_addr;
      wr_sel_n  = wr_sel;

      case (state)
         // Hreadyout is high in these states, so a new request may be accepted here.
         IDLE, RENABLE, WENABLE: begin
            psel_n = '0;
            if (valid && !Hwritereg) begin
               state_n  = READ;
               psel_n   = tempselx;
               paddr_n  = Haddr1;
               pwrite_n = 1'b0;
               hready_n = 1'b0;
            end else if (valid) begin
               state_n   = WWAIT;
               wr_addr_n = Haddr1;
               wr_sel_n  = tempselx;
               hready_n  = 1'b0;
            end
         end
         // Write data arrives one cycle after the request, so it is captured here.
         WWAIT: begin
            state_n  = WRITE;
            psel_n   = wr_sel;
            paddr_n  = wr_addr;
            pwdata_n = Hwdata1;
            pwrite_n = 1'b1;
            hready_n = 1'b0;
         end
         // An undecoded transfer is still sequenced, but never raises Penable without a select.
         READ, WRITE: begin
            state_n   = (state == READ) ? RENABLE : WENABLE;
            penable_n = |Pselx;
         end
         default: begin
            state_n   = IDLE;
            psel_n    = '0;
            pwrite_n  = 1'b0;
            paddr_n   = '0;
            pwdata_n  = '0;
            wr_addr_n = '0;
            wr_sel_n  = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state     <= IDLE;
         Pselx     <= '0;
         Penable   <= 1'b0;
         Pwrite    <= 1'b0;
         Paddr     <= '0;
         Pwdata    <= '0;
         Hreadyout <= 1'b1;
         wr_addr   <= '0;
         wr_sel    <= '0;
      end else begin
         state     <= state_n;
         Pselx     <= psel_n;
         Penable   <= penable_n;
         Pwrite    <= pwrite_n;
         Paddr     <= paddr_n;
         Pwdata    <= pwdata_n;
         Hreadyout <= hready_n;
         wr_addr   <= wr_addr_n;
         wr_sel    <= wr_sel_n;
      end
   end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Self-checking bench for apb_fsm_controller: directed transfers, with a scoreboard
// of expected APB accesses checked by a monitor on every enable cycle.
module tb_apb_fsm_controller;

   logic        Hclk = 1'b0;
   logic        Hresetn;
   logic        valid;
   logic        Hwritereg;
   logic [31:0] Haddr1;
   logic [31:0] Hwdata1;
   logic [2:0]  tempselx;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic        Hreadyout;

   typedef struct {
      logic [2:0]  sel;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
   } acc_t;

   acc_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   logic prev_en = 1'b0;

   apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) dut (
      .Hclk      (Hclk),
      .Hresetn   (Hresetn),
      .valid     (valid),
      .Hwritereg (Hwritereg),
      .Haddr1    (Haddr1),
      .Hwdata1   (Hwdata1),
      .tempselx  (tempselx),
      .Pselx     (Pselx),
      .Penable   (Penable),
      .Pwrite    (Pwrite),
      .Paddr     (Paddr),
      .Pwdata    (Pwdata),
      .Hreadyout (Hreadyout)
   );

   always #5 Hclk = ~Hclk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic w, input logic [31:0] a, input logic [2:0] s);
      valid     = v;
      Hwritereg = w;
      Haddr1    = a;
      tempselx  = s;
   endtask

   task automatic push(input logic [2:0] s, input logic [31:0] a, input logic w, input logic [31:0] d);
      acc_t e;
      e.sel = s; e.addr = a; e.wr = w; e.wdata = d;
      exp_q.push_back(e);
   endtask

   task automatic chk_state(input string name, input logic [2:0] s, input logic en, input logic rdy);
      check({name, "_psel"}, 64'(Pselx), 64'(s));
      check({name, "_penable"}, 64'(Penable), 64'(en));
      check({name, "_hready"}, 64'(Hreadyout), 64'(rdy));
   endtask

   task automatic chk_reset(input string name);
      chk_state(name, 3'b000, 1'b0, 1'b1);
      check({name, "_paddr"}, 64'(Paddr), 64'h0);
      check({name, "_pwdata"}, 64'(Pwdata), 64'h0);
   endtask

   // Monitor: every enable cycle must match the oldest expected access.
   always @(negedge Hclk) begin
      if (Hresetn === 1'b1 && Penable === 1'b1) begin
         check("enable_width", 64'(prev_en), 64'h0);
         if (exp_q.size() == 0) begin
            check("unexpected_enable", 64'(Penable), 64'h0);
         end else begin
            acc_t e;
            e = exp_q.pop_front();
            check("mon_psel", 64'(Pselx), 64'(e.sel));
            check("mon_paddr", 64'(Paddr), 64'(e.addr));
            check("mon_pwrite", 64'(Pwrite), 64'(e.wr));
            check("mon_hready", 64'(Hreadyout), 64'h1);
            if (e.wr) check("mon_pwdata", 64'(Pwdata), 64'(e.wdata));
         end
      end
      prev_en = Penable;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held for 100 ns with random inputs.
      Hresetn = 1'b0;
      Hwdata1 = '0;
      set_req(1'b0, 1'b0, '0, '0);
      repeat (10) begin
         set_req(1'($urandom), 1'($urandom), $urandom, 3'($urandom));
         Hwdata1 = $urandom;
         #10;
         chk_reset("rst_hold");
      end
      set_req(1'b0, 1'b0, '0, '0);
      #2 Hresetn = 1'b1;
      tick();

      // Invalid address with valid low: stays idle.
      set_req(1'b0, 1'b0, 32'h9000_0000, 3'b100);
      repeat (3) tick();
      chk_state("invalid_idle", 3'b000, 1'b0, 1'b1);

      // Single read.
      set_req(1'b1, 1'b0, 32'h8400_0002, 3'b010);
      push(3'b010, 32'h8400_0002, 1'b0, '0);
      tick();
      chk_state("rd_setup", 3'b010, 1'b0, 1'b0);
      check("rd_setup_paddr", 64'(Paddr), 64'h8400_0002);
      check("rd_setup_pwrite", 64'(Pwrite), 64'h0);
      valid = 1'b0;
      tick();
      chk_state("rd_enable", 3'b010, 1'b1, 1'b1);
      tick();
      chk_state("rd_idle", 3'b000, 1'b0, 1'b1);
      check("rd_idle_paddr_hold", 64'(Paddr), 64'h8400_0002);

      // Single write, then a back-to-back read issued during WENABLE.
      set_req(1'b1, 1'b1, 32'h8000_0001, 3'b001);
      push(3'b001, 32'h8000_0001, 1'b1, 32'hDEAD_BEEF);
      tick();
      chk_state("wr_wait", 3'b000, 1'b0, 1'b0);
      check("wr_wait_paddr_hold", 64'(Paddr), 64'h8400_0002);
      set_req(1'b0, 1'b0, 32'h1111_1111, 3'b111);
      Hwdata1 = 32'hDEAD_BEEF;
      tick();
      chk_state("wr_setup", 3'b001, 1'b0, 1'b0);
      check("wr_setup_paddr", 64'(Paddr), 64'h8000_0001);
      check("wr_setup_pwdata", 64'(Pwdata), 64'hDEAD_BEEF);
      check("wr_setup_pwrite", 64'(Pwrite), 64'h1);
      Hwdata1 = 32'h0;
      tick();
      chk_state("wr_enable", 3'b001, 1'b1, 1'b1);
      set_req(1'b1, 1'b0, 32'h8800_0004, 3'b100);
      push(3'b100, 32'h8800_0004, 1'b0, '0);
      tick();
      chk_state("b2b_setup", 3'b100, 1'b0, 1'b0);
      check("b2b_paddr", 64'(Paddr), 64'h8800_0004);
      check("b2b_pwrite", 64'(Pwrite), 64'h0);
      check("b2b_pwdata_hold", 64'(Pwdata), 64'hDEAD_BEEF);
      valid = 1'b0;
      tick();
      chk_state("b2b_enable", 3'b100, 1'b1, 1'b1);
      tick();
      chk_state("b2b_idle", 3'b000, 1'b0, 1'b1);

      // valid toggling during READ is ignored.
      set_req(1'b1, 1'b0, 32'h8400_0010, 3'b010);
      push(3'b010, 32'h8400_0010, 1'b0, '0);
      tick();
      set_req(1'b1, 1'b1, 32'h8000_0020, 3'b001);
      tick();
      chk_state("rd_ignore_enable", 3'b010, 1'b1, 1'b1);
      check("rd_ignore_paddr", 64'(Paddr), 64'h8400_0010);
      valid = 1'b0;
      tick();
      chk_state("rd_ignore_idle", 3'b000, 1'b0, 1'b1);

      // valid toggling during WRITE is ignored.
      set_req(1'b1, 1'b1, 32'h8000_0030, 3'b001);
      push(3'b001, 32'h8000_0030, 1'b1, 32'h1234_5678);
      tick();
      valid   = 1'b0;
      Hwdata1 = 32'h1234_5678;
      tick();
      set_req(1'b1, 1'b0, 32'h8800_0040, 3'b100);
      Hwdata1 = 32'h0;
      tick();
      chk_state("wr_ignore_enable", 3'b001, 1'b1, 1'b1);
      check("wr_ignore_paddr", 64'(Paddr), 64'h8000_0030);
      valid = 1'b0;
      tick();
      chk_state("wr_ignore_idle", 3'b000, 1'b0, 1'b1);

      // Reset dropped in the WRITE setup cycle: the access never completes.
      set_req(1'b1, 1'b1, 32'h8000_0050, 3'b001);
      tick();
      valid   = 1'b0;
      Hwdata1 = 32'hCAFE_F00D;
      tick();
      chk_state("rstw_setup", 3'b001, 1'b0, 1'b0);
      #2 Hresetn = 1'b0;
      #1 chk_reset("rstw_async");
      repeat (2) tick();
      chk_reset("rstw_held");
      #2 Hresetn = 1'b1;
      repeat (3) tick();
      chk_reset("rstw_after");

      check("queue_empty", 64'(exp_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_fsm_controller.md
Name: apb_fsm_controller

Overview:
APB master-side sequencer of the AHB2APB bridge, directly downstream of the AHB slave interface. It consumes the slave interface's decoded transfer (valid, Hwritereg, Haddr1, Hwdata1, tempselx) and drives the APB setup/enable protocol. It returns Hreadyout to stall the AHB side while an APB access is in flight. Prdata→Hrdata routing stays in the slave interface; this block does not touch read data.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
NSEL, 3, number of APB slave selects (one-hot)

Ports:
Hclk  input  1  bridge clock, rising edge
Hresetn  input  1  asynchronous active-low reset
valid  input  1  registered AHB transfer request
Hwritereg  input  1  direction of the flagged transfer (1 = write)
Haddr1  input  ADDR_W  address of the flagged transfer
Hwdata1  input  DATA_W  write data of the flagged transfer (valid one cycle after valid)
tempselx  input  NSEL  one-hot slave decode of the flagged transfer
Pselx  output  NSEL  APB select, registered
Penable  output  1  APB enable, registered
Pwrite  output  1  APB direction, registered
Paddr  output  ADDR_W  APB address, registered
Pwdata  output  DATA_W  APB write data, registered
Hreadyout  output  1  AHB ready, registered; 0 stalls the master

Behaviour:
- Alignment: valid, Hwritereg, Haddr1 and tempselx describe the same transfer in the same cycle n. For a write, its data is on Hwdata1 in cycle n+1.
- Reset (Hresetn low, async): state IDLE; Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1; internal wr_addr/wr_sel = 0.
- Request sampling: valid is sampled only in IDLE, RENABLE and WENABLE, the states where Hreadyout=1. It is ignored elsewhere.
- States and transitions. Outputs are registered and take the listed values in the named state.
  - IDLE: Pselx=0, Penable=0, Hreadyout=1.
    - valid & ~Hwritereg → READ.
    - valid & Hwritereg → WWAIT.
    - otherwise stay in IDLE.
  - WWAIT: Pselx=0, Penable=0, Hreadyout=0. On entry, latch wr_addr=Haddr1 and wr_sel=tempselx. Next state is always WRITE.
  - READ (setup): Pselx=tempselx, Paddr=Haddr1 (both sampled at the transition), Pwrite=0, Penable=0, Hreadyout=0. Next state is always RENABLE.
  - RENABLE: Penable=1, Hreadyout=1. Pselx, Paddr and Pwrite are held.
  - WRITE (setup): Pselx=wr_sel, Paddr=wr_addr, Pwdata=Hwdata1 (sampled at the WWAIT→WRITE edge), Pwrite=1, Penable=0, Hreadyout=0. Next state is always WENABLE.
  - WENABLE: Penable=1, Hreadyout=1. Pselx, Paddr, Pwdata and Pwrite are held.
  - From RENABLE or WENABLE:
    - valid & ~Hwritereg → READ (back-to-back, Penable drops for the new setup).
    - valid & Hwritereg → WWAIT.
    - otherwise → IDLE (Pselx=0, Penable=0).
- Latency, valid seen at edge k:
  - Read: setup cycle k+1, enable cycle k+2, Hreadyout high again in k+2.
  - Write: WWAIT k+1, setup k+2, enable k+3.
- Signal-hold rules:
  - Paddr, Pwdata and Pwrite keep their last values in IDLE and WWAIT. They are not cleared.
  - Penable is never 1 unless Pselx≠0.
  - Penable is high for exactly one cycle per access (no PREADY support).
- tempselx=0 with valid=1 (undecoded address) is still sequenced, with Pselx=0. Normally valid=0 for invalid addresses, so this should not occur.
- Reset mid-access: Hresetn falling in any state immediately forces the reset values. No APB access completes, and there is no replay after release.
- Encoded state register is 3 bits; unused codes return to IDLE with reset output values.

Test Plan:
- Reset: hold Hresetn=0 for 100 ns with random inputs → Pselx=0, Penable=0, Paddr=0, Pwdata=0, Hreadyout=1 throughout. Assert Hresetn low asynchronously mid-clock → outputs clear before the next edge.
- Single read: valid=1, Hwritereg=0, Haddr1=0x8400_0002, tempselx=3'b010 for one cycle → next cycle Pselx=010, Paddr=0x8400_0002, Pwrite=0, Penable=0, Hreadyout=0; following cycle Penable=1, Hreadyout=1; then IDLE with Pselx=0.
- Single write: valid=1, Hwritereg=1, Haddr1=0x8000_0001, tempselx=001; next cycle Hwdata1=0xDEADBEEF → WWAIT (Hreadyout=0), then setup with Pselx=001, Paddr=0x8000_0001, Pwdata=0xDEADBEEF, Pwrite=1, then enable cycle with Penable=1, Hreadyout=1.
- Back-to-back: write to 0x8000_0001 followed by read at 0x8800_0004 (tempselx=100) with valid high in WENABLE → WENABLE goes straight to READ setup. Penable goes 1→0, Pselx switches 001→100, no IDLE cycle in between.
- Invalid address: valid=0 with Haddr1=0x9000_0000 → FSM stays in IDLE, Pselx=0, Hreadyout=1. Also, valid toggling during READ or WRITE is ignored.
- Reset mid-write: drop Hresetn during WRITE → Penable never rises, Pselx=0 immediately. After release with valid=0, the FSM stays in IDLE.
